lu_issue_queue: RTL and testbench

Buffered issue stage directly upstream of the logic unit in a VLIW execution slot. Accepts logic-class operations (opcode, two operands, destination register tag) from the decode/dispatch slot, queues up to DEPTH of them in order, and presents one per cycle to the logic unit. Captures each result with its tag and an illegal-opcode flag in an output register, which is handed to writeback over a valid/ready handshake.

---
 rtl/lu_pkg.sv | 23 ++
 rtl/lu_fifo.sv | 63 ++++++
 rtl/lu_issue_queue.sv | 116 +++++++++++
 tb/tb_lu_issue_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit issue path.
//   LU_OP_W      : opcode width
//   LU_AND..NEG  : logic-class opcode values (a contiguous block, 01010..10001)
//   lu_is_legal  : true when an opcode belongs to the logic-op set
package lu_pkg;

    localparam int LU_OP_W = 5;

    localparam logic [LU_OP_W-1:0] LU_AND  = 5'b01010;
    localparam logic [LU_OP_W-1:0] LU_OR   = 5'b01011;
    localparam logic [LU_OP_W-1:0] LU_XOR  = 5'b01100;
    localparam logic [LU_OP_W-1:0] LU_NAND = 5'b01101;
    localparam logic [LU_OP_W-1:0] LU_NOR  = 5'b01110;
    localparam logic [LU_OP_W-1:0] LU_XNOR = 5'b01111;
    localparam logic [LU_OP_W-1:0] LU_NOT  = 5'b10000;
    localparam logic [LU_OP_W-1:0] LU_NEG  = 5'b10001;

    // The legal opcodes form one contiguous range, so a range check suffices.
    function automatic logic lu_is_legal(input logic [LU_OP_W-1:0] op);
        return (op >= LU_AND) && (op <= LU_NEG);
    endfunction

endpackage

// File: rtl/lu_fifo.sv
// In-order FIFO with occupancy count and synchronous active-high reset.
//   clk, rst       : clock, synchronous reset
//   push, wdata    : write an entry (caller guarantees !full)
//   pop            : retire the head entry (caller guarantees !empty)
//   rdata          : head entry, combinational read so the head can be evaluated in the same cycle
//   count          : occupancy, 0..DEPTH
//   full, empty    : occupancy flags
module lu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [CW-1:0] count_reg;

    // Storage carries no reset: contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign rdata = mem[rptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/lu_issue_queue.sv
// Buffered issue stage in front of the logic unit.
// Queues up to DEPTH logic ops in order, evaluates the head combinationally and
// captures {result, tag, illegal flag} in an output register drained over valid/ready.
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid/in_ready                 : dispatch handshake; in_ready depends only on rst and count
//   in_op, in_a, in_b, in_rd          : opcode, operands, destination tag
//   out_valid/out_ready               : writeback handshake
//   out_c, out_rd, out_illegal        : registered result, tag, illegal-opcode flag
//   count                             : queue occupancy (excludes the output register)
module lu_issue_queue
    import lu_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int RW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LU_OP_W-1:0]       in_op,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    input  logic [RW-1:0]            in_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_c,
    output logic [RW-1:0]            out_rd,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ENTRY_W = LU_OP_W + 2*N + RW;

    logic               full;
    logic               empty;
    logic               push;
    logic               issue;
    logic [ENTRY_W-1:0] head;

    logic [LU_OP_W-1:0] head_op;
    logic [N-1:0]       head_a;
    logic [N-1:0]       head_b;
    logic [RW-1:0]      head_rd;
    logic [N-1:0]       logic_res;
    logic               head_legal;

    logic               out_valid_reg;
    logic [N-1:0]       out_c_reg;
    logic [RW-1:0]      out_rd_reg;
    logic               out_illegal_reg;

    // A same-cycle issue never opens a push slot when full: in_ready looks at count only.
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;
    assign issue    = !empty && (!out_valid_reg || out_ready);

    lu_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .wdata ({in_op, in_a, in_b, in_rd}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign {head_op, head_a, head_b, head_rd} = head;

    // Head evaluation; illegal opcodes fall to the zero default so no unknown
    // value can be captured into out_c.
    always_comb begin
        logic_res = '0;
        case (head_op)
            LU_AND:  logic_res = head_a & head_b;
            LU_OR:   logic_res = head_a | head_b;
            LU_XOR:  logic_res = head_a ^ head_b;
            LU_NAND: logic_res = ~(head_a & head_b);
            LU_NOR:  logic_res = ~(head_a | head_b);
            LU_XNOR: logic_res = ~(head_a ^ head_b);
            LU_NOT:  logic_res = ~head_a;
            LU_NEG:  logic_res = N'(0) - head_a;
            default: logic_res = '0;
        endcase
    end

    assign head_legal = lu_is_legal(head_op);

    // Output register: load on issue, clear valid on drain-only, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            out_c_reg       <= '0;
            out_rd_reg      <= '0;
            out_illegal_reg <= 1'b0;
        end else if (issue) begin
            out_valid_reg   <= 1'b1;
            out_c_reg       <= head_legal ? logic_res : '0;
            out_rd_reg      <= head_rd;
            out_illegal_reg <= !head_legal;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg   <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_c       = out_c_reg;
    assign out_rd      = out_rd_reg;
    assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_lu_issue_queue.sv
// Self-checking bench for lu_issue_queue: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_lu_issue_queue;
    import lu_pkg::*;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int RW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [RW-1:0] in_rd;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_c;
    logic [RW-1:0] out_rd;
    logic          out_illegal;
    logic [2:0]    count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lu_issue_queue #(.N(N), .DEPTH(DEPTH), .RW(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_c       (out_c),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .count       (count)
    );

    typedef struct packed {
        logic [4:0]    op;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [RW-1:0] rd;
    } op_t;

    // Reference model: pending ops in push order plus the output register.
    op_t           mq[$];
    logic          m_ov;
    logic [N-1:0]  m_c;
    logic [RW-1:0] m_rd;
    logic          m_ill;

    function automatic logic [N:0] ref_eval(input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        // Returns {illegal, result}.
        case (int'(op))
            10: return {1'b0, a & b};
            11: return {1'b0, a | b};
            12: return {1'b0, a ^ b};
            13: return {1'b0, ~(a & b)};
            14: return {1'b0, ~(a | b)};
            15: return {1'b0, ~(a ^ b)};
            16: return {1'b0, ~a};
            17: return {1'b0, N'((64'd1 << N) - {32'd0, a})};
            default: return {1'b1, {N{1'b0}}};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [RW-1:0] rd);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
    endtask

    // One clock: check in_ready before the edge, advance the model, then
    // compare every registered output 1 time unit after the edge.
    task automatic cycle();
        logic          do_push;
        logic          do_issue;
        logic [N:0]    r;
        op_t           h;
        op_t           e;
        #1;
        chk("in_ready", N'(in_ready), N'(!rst && (mq.size() != DEPTH)));
        if (rst) begin
            mq.delete();
            m_ov = 1'b0; m_c = '0; m_rd = '0; m_ill = 1'b0;
        end else begin
            do_push  = in_valid && (mq.size() != DEPTH);
            do_issue = (mq.size() != 0) && (!m_ov || out_ready);
            if (do_issue) begin
                h     = mq.pop_front();
                r     = ref_eval(h.op, h.a, h.b);
                m_ov  = 1'b1;
                m_c   = r[N-1:0];
                m_ill = r[N];
                m_rd  = h.rd;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (do_push) begin
                e.op = in_op; e.a = in_a; e.b = in_b; e.rd = in_rd;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("count", N'(count), N'(mq.size()));
        chk("out_valid", N'(out_valid), N'(m_ov));
        chk("out_c", out_c, m_c);
        chk("out_rd", N'(out_rd), N'(m_rd));
        chk("out_illegal", N'(out_illegal), N'(m_ill));
        $display("t=%0t rst=%0b in_v=%0b op=%h rd=%0d out_rdy=%0b | out_v=%0b c=%h rd=%0d ill=%0b cnt=%0d",
                 $time, rst, in_valid, in_op, in_rd, out_ready, out_valid, out_c, out_rd, out_illegal, count);
    endtask

    initial begin
        m_ov = 1'b0; m_c = '0; m_rd = '0; m_ill = 1'b0;
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b0, 5'd0, '0, '0, '0);
        cycle();
        cycle();
        rst = 1'b0;

        // AND: issue one edge after push, then drain.
        drive(1'b1, LU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3);
        cycle();
        chk("and_not_yet_valid", N'(out_valid), 32'd0);
        in_valid = 1'b0;
        cycle();
        chk("and_valid", N'(out_valid), 32'd1);
        chk("and_c", out_c, 32'hF000F000);
        chk("and_rd", N'(out_rd), 32'd3);
        chk("and_ill", N'(out_illegal), 32'd0);
        chk("and_count", N'(count), 32'd0);
        cycle();

        // NEG/NEG/NOT back-to-back, results on consecutive cycles.
        drive(1'b1, LU_NEG, 32'h00000001, 32'h12345678, 5'd1);
        cycle();
        drive(1'b1, LU_NEG, 32'h80000000, 32'h0, 5'd2);
        cycle();
        chk("neg1_c", out_c, 32'hFFFFFFFF);
        drive(1'b1, LU_NOT, 32'h0, 32'hFFFFFFFF, 5'd4);
        cycle();
        chk("negmin_c", out_c, 32'h80000000);
        in_valid = 1'b0;
        cycle();
        chk("not0_c", out_c, 32'hFFFFFFFF);
        cycle();

        // Back-pressure: 5 pushes fill output register plus 4 queue entries.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, LU_XOR, $urandom, $urandom, 5'(i + 10));
            cycle();
        end
        chk("bp_count_full", N'(count), 32'd4);
        chk("bp_in_ready_full", N'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("bp_count_after_pulse", N'(count), 32'd3);
        chk("bp_in_ready_after_pulse", N'(in_ready), 32'd1);
        chk("bp_rd_after_pulse", N'(out_rd), 32'd11);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Illegal opcode passes through with zero result, then a legal XOR.
        drive(1'b1, 5'b00011, $urandom, $urandom, 5'd7);
        cycle();
        drive(1'b1, LU_XOR, 32'hAAAAAAAA, 32'h55555555, 5'd9);
        cycle();
        chk("ill_c", out_c, 32'h0);
        chk("ill_rd", N'(out_rd), 32'd7);
        chk("ill_flag", N'(out_illegal), 32'd1);
        in_valid = 1'b0;
        cycle();
        chk("xor_c", out_c, 32'hFFFFFFFF);
        chk("xor_ill", N'(out_illegal), 32'd0);
        cycle();

        // Simultaneous push+issue at count=2, then keep streaming through the wrap.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, LU_OR, $urandom, $urandom, 5'(i + 20));
            cycle();
        end
        chk("simul_pre_count", N'(count), 32'd2);
        out_ready = 1'b1;
        drive(1'b1, LU_NAND, $urandom, $urandom, 5'd23);
        cycle();
        chk("simul_count", N'(count), 32'd2);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'(10 + (i % 8)), $urandom, $urandom, 5'(24 + i));
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Reset mid-operation discards everything.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, LU_XNOR, $urandom, $urandom, 5'(i + 1));
            cycle();
        end
        chk("rst_pre_valid", N'(out_valid), 32'd1);
        chk("rst_pre_count", N'(count), 32'd3);
        rst = 1'b1;
        cycle();
        chk("rst_in_ready", N'(in_ready), 32'd0);
        chk("rst_out_valid", N'(out_valid), 32'd0);
        chk("rst_count", N'(count), 32'd0);
        chk("rst_out_c", out_c, 32'h0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", N'(in_ready), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [4:0]   op;
            logic [N-1:0] a;
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(10 + $urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h80000000;
                default: a = $urandom;
            endcase
            drive($urandom_range(0, 3) != 0, op, a, $urandom, 5'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
